// File: rtl/button_event_pkg.sv
// Shared definitions for the button event path: FSM state encoding and timer width.
// Also imported by the pattern-select FSM, so the package keeps the name btn_event_pkg.
package btn_event_pkg;

    localparam int unsigned TMR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } btn_state_t;

endpackage

// File: rtl/button_event_if.sv
// Event bundle between the button event block and its consumer (mode/pattern select).
// master = event producer, slave = event consumer.
interface button_event_if;

    logic       db;
    logic       pressed;
    logic       press;
    logic       rls;
    logic       long_evt;
    logic       rpt;
    logic [7:0] press_cnt;

    modport master (
        input  db,
        output pressed, press, rls, long_evt, rpt, press_cnt
    );

    modport slave (
        output db,
        input  pressed, press, rls, long_evt, rpt, press_cnt
    );

endinterface

// File: rtl/button_event_timer.sv
// Cycle timer: clear has priority, counts while enabled, o_done is high in the cycle the
// count reaches TERMINAL-1 with enable. RELOAD=0 saturates at TERMINAL, RELOAD=1 restarts.
module event_timer
    import btn_event_pkg::*;
#(
    parameter logic [TMR_W-1:0] TERMINAL = TMR_W'(2),
    parameter bit               RELOAD   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    localparam logic [TMR_W-1:0] LAST = TERMINAL - TMR_W'(1);

    logic [TMR_W-1:0] cnt_q;

    assign o_done = i_en && !i_clr && (cnt_q == LAST);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en && (cnt_q != TERMINAL)) begin
            if (RELOAD && o_done) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + TMR_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_event.sv
// Debounced button level -> registered press/release/long/repeat pulses and press counter.
// Auto-repeat in the LONG state exists only when BTN_REPEAT_EN is defined.
module button_event
    import btn_event_pkg::*;
#(
    parameter bit          ACTIVE_HIGH   = 1'b1,
    parameter int unsigned LONG_COUNT    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 2_500_000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_db,
    output logic       o_pressed,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long,
    output logic       o_repeat,
    output logic [7:0] o_press_cnt
);

    btn_state_t state_q, state_d;
    logic       btn;
    logic       armed_q;
    logic       press_d, rel_d, long_d, pressed_d;
    logic [7:0] cnt_d;
    logic       long_clr, long_en, long_done;

    assign btn = ACTIVE_HIGH ? i_db : ~i_db;

    // Enable is gated by btn so a release sampled on the terminal cycle suppresses o_long.
    assign long_clr = (state_q == IDLE);
    assign long_en  = (state_q == HELD) && btn;

    event_timer #(
        .TERMINAL (TMR_W'(LONG_COUNT)),
        .RELOAD   (1'b0)
    ) u_long_tmr (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_clr  (long_clr),
        .i_en   (long_en),
        .o_done (long_done)
    );

    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        cnt_d   = o_press_cnt;
        unique case (state_q)
            IDLE: begin
                if (btn && armed_q) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    cnt_d   = o_press_cnt + 8'd1;
                end
            end
            HELD: begin
                if (!btn) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end else if (long_done) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            LONG: begin
                if (!btn) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        pressed_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            o_pressed   <= 1'b0;
            o_press     <= 1'b0;
            o_release   <= 1'b0;
            o_long      <= 1'b0;
            o_press_cnt <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_q | ~btn;
            o_pressed   <= pressed_d;
            o_press     <= press_d;
            o_release   <= rel_d;
            o_long      <= long_d;
            o_press_cnt <= cnt_d;
        end
    end

`ifdef BTN_REPEAT_EN
    logic rep_clr, rep_en, rep_done;

    // Cleared outside LONG, so the first pulse lands REPEAT_PERIOD cycles after o_long.
    assign rep_clr = (state_q != LONG);
    assign rep_en  = (state_q == LONG) && btn;

    event_timer #(
        .TERMINAL (TMR_W'(REPEAT_PERIOD)),
        .RELOAD   (1'b1)
    ) u_rep_tmr (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_clr  (rep_clr),
        .i_en   (rep_en),
        .o_done (rep_done)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_repeat <= 1'b0;
        end else begin
            o_repeat <= rep_done;
        end
    end
`else
    logic unused_repeat_period;

    assign unused_repeat_period = ^REPEAT_PERIOD;
    assign o_repeat             = 1'b0;
`endif

endmodule
